// File: rtl/count_seq_ctrl_pkg.sv
// Shared state encoding and defaults for the count sequencer.
// Internal states are distinct; PAUSE and DONE share one debug code on the LEDs.
package count_seq_ctrl_pkg;

  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int CNT_W_DEFAULT    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } seq_state_t;

  localparam logic [1:0] CODE_IDLE  = 2'd0;
  localparam logic [1:0] CODE_CLEAR = 2'd1;
  localparam logic [1:0] CODE_RUN   = 2'd2;
  localparam logic [1:0] CODE_HOLD  = 2'd3;

  function automatic logic [1:0] state_code(input seq_state_t s);
    logic [1:0] code;
    case (s)
      S_IDLE:  code = CODE_IDLE;
      S_CLEAR: code = CODE_CLEAR;
      S_RUN:   code = CODE_RUN;
      default: code = CODE_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/count_seq_ctrl_rise_edge.sv
// Registered rising-edge detector for a key level.
// History resets high so a key already held during reset never looks like a press.
module rise_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Pulse
);

  logic prev;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      prev  <= 1'b1;
      Pulse <= 1'b0;
    end else begin
      prev  <= D;
      Pulse <= D & ~prev;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Run/pause/clear sequencer for the 1 s tick up-counter.
// Owns the prescaler and turns Start/Stop presses into counter enable/clear pulses.
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [CNT_W-1:0] Target,
  input  logic [CNT_W-1:0] Count_Q,
  output logic             Cnt_En,
  output logic             Cnt_Clr,
  output logic             Tick,
  output logic             Done,
  output logic [1:0]       State
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic start_rise;
  logic stop_rise;

  seq_state_t cur_state;
  seq_state_t nxt_state;
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] presc_nxt;
  logic en_nxt;
  logic clr_nxt;
  logic tick_nxt;
  logic at_target;
  logic last_cycle;

  rise_edge u_start_edge (
    .Clk   (Clk),
    .Rst   (Rst),
    .D     (Start),
    .Pulse (start_rise)
  );

  rise_edge u_stop_edge (
    .Clk   (Clk),
    .Rst   (Rst),
    .D     (Stop),
    .Pulse (stop_rise)
  );

  assign at_target  = (Count_Q == Target);
  assign last_cycle = (presc == PRE_LAST);

  // Outputs are registered from next-state decode so they line up with State.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cur_state <= S_IDLE;
      presc     <= '0;
      Cnt_En    <= 1'b0;
      Cnt_Clr   <= 1'b0;
      Tick      <= 1'b0;
      Done      <= 1'b0;
      State     <= CODE_IDLE;
    end else begin
      cur_state <= nxt_state;
      presc     <= presc_nxt;
      Cnt_En    <= en_nxt;
      Cnt_Clr   <= clr_nxt;
      Tick      <= tick_nxt;
      Done      <= (nxt_state == S_DONE);
      State     <= state_code(nxt_state);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    presc_nxt = presc;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start_rise && !stop_rise) begin
          nxt_state = S_CLEAR;
          clr_nxt   = 1'b1;
        end
      end
      S_CLEAR: begin
        nxt_state = S_RUN;
        presc_nxt = '0;
      end
      S_RUN: begin
        // The tick action is always taken, even when a Stop arrives with it.
        if (last_cycle) begin
          tick_nxt  = 1'b1;
          presc_nxt = '0;
          if (!at_target) begin
            en_nxt = 1'b1;
          end else if (!Mode) begin
            clr_nxt = 1'b1;
          end else begin
            nxt_state = S_DONE;
          end
        end else if (!stop_rise) begin
          presc_nxt = presc + 1'b1;
        end
        if (stop_rise) begin
          nxt_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop_rise) begin
          nxt_state = S_IDLE;
          clr_nxt   = 1'b1;
          presc_nxt = '0;
        end else if (start_rise) begin
          nxt_state = S_RUN;
        end
      end
      S_DONE: begin
        if (stop_rise) begin
          nxt_state = S_IDLE;
          clr_nxt   = 1'b1;
        end else if (start_rise) begin
          nxt_state = S_CLEAR;
          clr_nxt   = 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: scenario table, hand sequences and
// randomized key/config activity compared every cycle against a behavioural model.
module tb_count_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             Start = 1'b0;
  logic             Stop = 1'b0;
  logic             Mode = 1'b0;
  logic [CNT_W-1:0] Target = '0;
  logic [CNT_W-1:0] Count_Q;
  logic             Cnt_En;
  logic             Cnt_Clr;
  logic             Tick;
  logic             Done;
  logic [1:0]       State;

  int testsRun = 0;
  int testsFailed = 0;

  count_seq_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Stop    (Stop),
    .Mode    (Mode),
    .Target  (Target),
    .Count_Q (Count_Q),
    .Cnt_En  (Cnt_En),
    .Cnt_Clr (Cnt_Clr),
    .Tick    (Tick),
    .Done    (Done),
    .State   (State)
  );

  always #5 Clk = ~Clk;

  // Stand-in for the T-flip-flop counter chain fed back as Count_Q
  always @(posedge Clk) begin
    if (!Rst) Count_Q <= 4'd9;
    else if (Cnt_Clr) Count_Q <= '0;
    else if (Cnt_En) Count_Q <= Count_Q + 1'b1;
  end

  // Behavioural model: phase, seconds elapsed and key history, output values after each edge
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int   mPhase = M_IDLE;
  int   mElapsed = 0;
  logic startSeen1 = 1'b1, startSeen2 = 1'b1, stopSeen1 = 1'b1, stopSeen2 = 1'b1;
  logic startRise, stopRise, tickNow, hitTarget;
  logic expEn = 1'b0, expClr = 1'b0, expTick = 1'b0, expDone = 1'b0;
  logic [1:0] expState = 2'd0;

  always @(posedge Clk) begin
    expEn = 1'b0;
    expClr = 1'b0;
    expTick = 1'b0;
    if (!Rst) begin
      mPhase = M_IDLE;
      mElapsed = 0;
      startSeen1 = 1'b1;
      startSeen2 = 1'b1;
      stopSeen1 = 1'b1;
      stopSeen2 = 1'b1;
    end else begin
      startRise = startSeen1 & ~startSeen2;
      stopRise = stopSeen1 & ~stopSeen2;
      tickNow = (mPhase == M_RUN) && (mElapsed == TICK_DIV - 1);
      hitTarget = (Count_Q == Target);
      if (tickNow) begin
        expTick = 1'b1;
        mElapsed = 0;
        if (!hitTarget) expEn = 1'b1;
        else if (!Mode) expClr = 1'b1;
      end else if (mPhase == M_RUN && !stopRise) begin
        mElapsed = mElapsed + 1;
      end
      case (mPhase)
        M_IDLE: if (startRise && !stopRise) begin mPhase = M_CLEAR; expClr = 1'b1; end
        M_CLEAR: begin mPhase = M_RUN; mElapsed = 0; end
        M_RUN: begin
          if (stopRise) mPhase = M_PAUSE;
          else if (tickNow && hitTarget && Mode) mPhase = M_DONE;
        end
        M_PAUSE: begin
          if (stopRise) begin mPhase = M_IDLE; expClr = 1'b1; end
          else if (startRise) mPhase = M_RUN;
        end
        default: begin
          if (stopRise) begin mPhase = M_IDLE; expClr = 1'b1; end
          else if (startRise) begin mPhase = M_CLEAR; expClr = 1'b1; end
        end
      endcase
      startSeen2 = startSeen1;
      startSeen1 = Start;
      stopSeen2 = stopSeen1;
      stopSeen1 = Stop;
    end
    expDone = (mPhase == M_DONE);
    expState = (mPhase == M_DONE) ? 2'd3 : 2'(mPhase);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge Clk) begin
    checkOutput("model_outputs", 32'({Cnt_En, Cnt_Clr, Tick, Done, State}),
                32'({expEn, expClr, expTick, expDone, expState}));
    checkOutput("en_clr_exclusive", 32'(Cnt_En & Cnt_Clr), 32'd0);
  end

  task automatic applyStimulus(input logic r, input logic s, input logic p);
    Rst = r;
    Start = s;
    Stop = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic resetDut();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] target;
    int         cycles;
    int         nEn;
    int         nClr;
    int         nTick;
    logic [1:0] state;
    logic       done;
    logic [3:0] q;
  } vec_t;

  vec_t vecs[7];
  int nEn, nClr, nTick, firstTick;
  logic [2:0] pauseSeen;
  logic rRand, sRand, pRand;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 4'd3,  20, 3, 2, 4, 2'd2, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 4'd3,  36, 6, 3, 8, 2'd2, 1'b0, 4'd0};
    vecs[2] = '{1'b1, 4'd5,  28, 5, 1, 6, 2'd3, 1'b1, 4'd5};
    vecs[3] = '{1'b0, 4'd0,  16, 0, 4, 3, 2'd2, 1'b0, 4'd0};
    vecs[4] = '{1'b1, 4'd0,  10, 0, 1, 1, 2'd3, 1'b1, 4'd0};
    vecs[5] = '{1'b0, 4'd15, 12, 2, 1, 2, 2'd2, 1'b0, 4'd2};
    vecs[6] = '{1'b1, 4'd1,  14, 1, 1, 2, 2'd3, 1'b1, 4'd1};

    // Key held through reset must not start anything
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_outputs", 32'({Cnt_En, Cnt_Clr, Tick, Done, State}), 32'd0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("held_start_idle", 32'({Cnt_En, Cnt_Clr, Tick, Done, State}), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("released_start_idle", 32'(State), 32'd0);

    // Scenario table: one Start press, then count pulses over a fixed window
    for (int v = 0; v < 7; v++) begin
      Mode = vecs[v].mode;
      Target = vecs[v].target;
      resetDut();
      nEn = 0; nClr = 0; nTick = 0;
      for (int k = 1; k <= vecs[v].cycles; k++) begin
        applyStimulus(1'b1, (k == 1), 1'b0);
        nEn += int'(Cnt_En);
        nClr += int'(Cnt_Clr);
        nTick += int'(Tick);
      end
      checkOutput($sformatf("vec%0d_en_count", v), 32'(nEn), 32'(vecs[v].nEn));
      checkOutput($sformatf("vec%0d_clr_count", v), 32'(nClr), 32'(vecs[v].nClr));
      checkOutput($sformatf("vec%0d_tick_count", v), 32'(nTick), 32'(vecs[v].nTick));
      checkOutput($sformatf("vec%0d_state", v), 32'(State), 32'(vecs[v].state));
      checkOutput($sformatf("vec%0d_done", v), 32'(Done), 32'(vecs[v].done));
      checkOutput($sformatf("vec%0d_count_q", v), 32'(Count_Q), 32'(vecs[v].q));
    end

    // Pause at prescaler 2, hold, resume, stop on a tick, then abort from PAUSE
    Mode = 1'b0;
    Target = 4'd3;
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pause_state", 32'({Done, State}), 32'b011);
    pauseSeen = '0;
    repeat (10) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      pauseSeen |= {Cnt_En, Cnt_Clr, Tick};
    end
    checkOutput("pause_quiet", 32'(pauseSeen), 32'd0);
    checkOutput("pause_hold_state", 32'(State), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", 32'(State), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_no_early_tick", 32'(Tick), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_tick", 32'({Tick, Cnt_En}), 32'b11);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop_tick_en", 32'({Tick, Cnt_En}), 32'b11);
    checkOutput("stop_tick_pause", 32'(State), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort_clr", 32'({Cnt_Clr, State}), 32'b100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort_clr_single", 32'({Cnt_Clr, State}), 32'b000);

    // Start and Stop rising together in RUN
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("both_edges_pause", 32'({Done, State}), 32'b011);

    // One-shot reaches DONE, then Start restarts from a clear
    Mode = 1'b1;
    Target = 4'd5;
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (27) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("done_reached", 32'({Done, State}), 32'b111);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_clear", 32'({Done, State, Cnt_Clr}), 32'b0011);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_run", 32'({Count_Q, State}), 32'({4'd0, 2'd2}));

    // Reset mid-second, then a fresh start ticks on schedule
    Mode = 1'b0;
    Target = 4'd3;
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrun_reset", 32'({Cnt_En, Cnt_Clr, Tick, Done, State}), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    firstTick = 0;
    for (int k = 2; k <= 12 && firstTick == 0; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (Tick) firstTick = k;
    end
    checkOutput("restart_first_tick", 32'(firstTick), 32'd7);

    // Random keys, config changes and occasional resets against the model
    for (int i = 0; i < 4000; i++) begin
      rRand = ($urandom_range(0, 299) != 0);
      sRand = ($urandom_range(0, 7) == 0) ? ~Start : Start;
      pRand = ($urandom_range(0, 11) == 0) ? ~Stop : Stop;
      if ($urandom_range(0, 59) == 0) Mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) Target = 4'($urandom_range(0, 15));
      applyStimulus(rRand, sRand, pRand);
    end

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
